// File: rtl/operand2_imm_encoder.sv
// ---------------------------------------------------------------------------
// operand2_imm_encoder
//
// Purpose
//   Finds the ARM data-processing rotate-immediate encoding {rot, imm8} of a
//   32-bit constant, so that ROR(imm8, 2*rot) == value. The search is
//   sequential and tests one rotation per cycle, smallest rot first. With
//   ALLOW_INVERT set, a value that has no encoding is searched again as
//   ~value, which lets the caller replace a MOV with an MVN.
//
// Parameters
//   ALLOW_INVERT   1: after a full miss, search again with ~value
//
// Ports
//   clk            clock, all state changes on the rising edge
//   rst            synchronous reset, active-high
//   in_valid       request valid
//   in_ready       request accepted when high (IDLE only)
//   in_value       constant to encode
//   out_valid      result valid (DONE only)
//   out_ready      consumer takes the result
//   shift_operand  {rot[3:0], imm8[7:0]}; zero when found=0
//   found          an encoding exists
//   inverted       the encoding is of ~in_value
// ---------------------------------------------------------------------------
module operand2_imm_encoder #(
  parameter bit ALLOW_INVERT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] shift_operand,
  output logic        found,
  output logic        inverted
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cand_q, cand_d;
  logic [3:0]  rot_q, rot_d;
  logic        inv_q, inv_d;
  logic [11:0] shift_q, shift_d;
  logic        found_q, found_d;
  logic        inverted_q, inverted_d;

  // Rotate-left of the candidate by 2*rot. Undoing ROR(imm8, 2*rot) this way
  // means the candidate is encodable at this rot exactly when the upper
  // 24 bits of the rotated word are zero. At shamt=0 the right shift is a
  // full 32 bits and contributes nothing, which is the intended result.
  logic [4:0]  shamt;
  logic [31:0] rolled;

  assign shamt  = {rot_q, 1'b0};
  assign rolled = (cand_q << shamt) | (cand_q >> (6'd32 - {1'b0, shamt}));

  // NOTE: every variable gets its hold value first so no path through the
  // case statement leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    rot_d      = rot_q;
    inv_d      = inv_q;
    shift_d    = shift_q;
    found_d    = found_q;
    inverted_d = inverted_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          cand_d  = in_value;
          rot_d   = 4'd0;
          inv_d   = 1'b0;
          state_d = SEARCH;
        end
      end

      SEARCH: begin
        if (rolled[31:8] == 24'd0) begin
          shift_d    = {rot_q, rolled[7:0]};
          found_d    = 1'b1;
          inverted_d = inv_q;
          state_d    = DONE;
        end else if (rot_q != 4'hF) begin
          rot_d = rot_q + 4'd1;
        end else if (ALLOW_INVERT && !inv_q) begin
          // The inverted pass always follows a complete non-inverted pass,
          // so a direct encoding is preferred over an MVN substitution.
          cand_d = ~cand_q;
          inv_d  = 1'b1;
          rot_d  = 4'd0;
        end else begin
          shift_d    = 12'h000;
          found_d    = 1'b0;
          inverted_d = 1'b0;
          state_d    = DONE;
        end
      end

      DONE: begin
        // A request presented together with out_ready is not taken here;
        // it is accepted from IDLE on the following edge.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cand_q     <= 32'd0;
      rot_q      <= 4'd0;
      inv_q      <= 1'b0;
      shift_q    <= 12'h000;
      found_q    <= 1'b0;
      inverted_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      rot_q      <= rot_d;
      inv_q      <= inv_d;
      shift_q    <= shift_d;
      found_q    <= found_d;
      inverted_q <= inverted_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign shift_operand = shift_q;
  assign found         = found_q;
  assign inverted      = inverted_q;

endmodule

// File: tb/tb_operand2_imm_encoder.sv
// ---------------------------------------------------------------------------
// tb_operand2_imm_encoder
//
// Bench for operand2_imm_encoder. Instance dut_a has ALLOW_INVERT=1 and
// instance dut_b has ALLOW_INVERT=0; each has its own request and response
// handshake, and the two share clk and rst. Expected encodings and latencies
// are worked out by hand; the random part checks the round-trip property by
// rotating imm8 back right and comparing with the requested value.
// ---------------------------------------------------------------------------
module tb_operand2_imm_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid_a = 1'b0, in_valid_b = 1'b0;
  logic [31:0] in_value_a = '0,   in_value_b = '0;
  logic        out_ready_a = 1'b0, out_ready_b = 1'b0;
  logic        in_ready_a, in_ready_b;
  logic        out_valid_a, out_valid_b;
  logic [11:0] so_a, so_b;
  logic        found_a, found_b;
  logic        inv_a, inv_b;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  operand2_imm_encoder #(.ALLOW_INVERT(1'b1)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid_a),
    .in_ready     (in_ready_a),
    .in_value     (in_value_a),
    .out_valid    (out_valid_a),
    .out_ready    (out_ready_a),
    .shift_operand(so_a),
    .found        (found_a),
    .inverted     (inv_a)
  );

  operand2_imm_encoder #(.ALLOW_INVERT(1'b0)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid_b),
    .in_ready     (in_ready_b),
    .in_value     (in_value_b),
    .out_valid    (out_valid_b),
    .out_ready    (out_ready_b),
    .shift_operand(so_b),
    .found        (found_b),
    .inverted     (inv_b)
  );

  function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
    if (s == 0) return x;
    return (x >> s) | (x << (32 - s));
  endfunction

  // Presents one request; returns #1 after the accept edge E0.
  task automatic start_req(input bit sel_b, input logic [31:0] v);
    @(negedge clk);
    if (sel_b) begin in_valid_b = 1'b1; in_value_b = v; end
    else       begin in_valid_a = 1'b1; in_value_a = v; end
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
  endtask

  // Counts edges after E0 until out_valid; lat=0 if it never rises.
  task automatic wait_done(input bit sel_b, output int lat);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if ((sel_b ? out_valid_b : out_valid_a) === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic release_result(input bit sel_b);
    if (sel_b) out_ready_b = 1'b1; else out_ready_a = 1'b1;
    @(posedge clk);
    #1;
    out_ready_a = 1'b0;
    out_ready_b = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({in_ready_a, out_valid_a, found_a, inv_a, so_a} !== {4'b1000, 12'h000}) begin
      mismatched++;
      $display("FAIL reset_a: got rdy/vld/fnd/inv/so=%b%b%b%b/%h want 1000/000",
               in_ready_a, out_valid_a, found_a, inv_a, so_a);
    end
    compared++;
    if ({in_ready_b, out_valid_b, found_b, inv_b, so_b} !== {4'b1000, 12'h000}) begin
      mismatched++;
      $display("FAIL reset_b: got rdy/vld/fnd/inv/so=%b%b%b%b/%h want 1000/000",
               in_ready_b, out_valid_b, found_b, inv_b, so_b);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit          sel_b;
    logic [31:0] value;
    logic [11:0] so;
    logic        fnd;
    logic        inv;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t vecs[12];
    int          lat;
    logic [11:0] so;
    logic        fnd, inv, rdy;
    vecs[0]  = '{1'b0, 32'h000000FF, 12'h0FF, 1'b1, 1'b0, 1};
    vecs[1]  = '{1'b0, 32'hFF000000, 12'h4FF, 1'b1, 1'b0, 5};
    vecs[2]  = '{1'b0, 32'hF000000F, 12'h2FF, 1'b1, 1'b0, 3};
    vecs[3]  = '{1'b0, 32'h00000104, 12'hF41, 1'b1, 1'b0, 16};
    vecs[4]  = '{1'b0, 32'h00000000, 12'h000, 1'b1, 1'b0, 1};
    vecs[5]  = '{1'b1, 32'h00000101, 12'h000, 1'b0, 1'b0, 16};
    vecs[6]  = '{1'b0, 32'hFFFFFF00, 12'h0FF, 1'b1, 1'b1, 17};
    vecs[7]  = '{1'b0, 32'h00000101, 12'h000, 1'b0, 1'b0, 32};
    vecs[8]  = '{1'b1, 32'hFFFFFF00, 12'h000, 1'b0, 1'b0, 16};
    vecs[9]  = '{1'b0, 32'hFFFFFFFF, 12'h000, 1'b1, 1'b1, 17};
    vecs[10] = '{1'b0, 32'h000003FC, 12'hFFF, 1'b1, 1'b0, 16};
    vecs[11] = '{1'b0, 32'h80000001, 12'h106, 1'b1, 1'b0, 2};
    foreach (vecs[i]) begin
      start_req(vecs[i].sel_b, vecs[i].value);
      wait_done(vecs[i].sel_b, lat);
      so  = vecs[i].sel_b ? so_b    : so_a;
      fnd = vecs[i].sel_b ? found_b : found_a;
      inv = vecs[i].sel_b ? inv_b   : inv_a;
      compared++;
      if (lat !== vecs[i].lat) begin
        mismatched++;
        $display("FAIL vec%0d_latency (%h): got %0d want %0d", i, vecs[i].value, lat, vecs[i].lat);
      end
      compared++;
      if (so !== vecs[i].so) begin
        mismatched++;
        $display("FAIL vec%0d_shift_operand (%h): got %h want %h", i, vecs[i].value, so, vecs[i].so);
      end
      compared++;
      if (fnd !== vecs[i].fnd) begin
        mismatched++;
        $display("FAIL vec%0d_found (%h): got %b want %b", i, vecs[i].value, fnd, vecs[i].fnd);
      end
      compared++;
      if (inv !== vecs[i].inv) begin
        mismatched++;
        $display("FAIL vec%0d_inverted (%h): got %b want %b", i, vecs[i].value, inv, vecs[i].inv);
      end
      release_result(vecs[i].sel_b);
      rdy = vecs[i].sel_b ? in_ready_b : in_ready_a;
      compared++;
      if (rdy !== 1'b1) begin
        mismatched++;
        $display("FAIL vec%0d_ready_after_release: got %b want 1", i, rdy);
      end
    end
  endtask

  // Result stays frozen while out_ready is low; in_valid in DONE is ignored;
  // out_ready with in_valid in DONE only returns to IDLE.
  task automatic test_hold_and_handover();
    int lat;
    int bad = 0;
    start_req(1'b0, 32'hFF000000);
    wait_done(1'b0, lat);
    compared++;
    if (lat !== 5) begin
      mismatched++;
      $display("FAIL hold_latency: got %0d want 5", lat);
    end
    in_valid_a = 1'b1;
    in_value_a = 32'h000000FF;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if ({out_valid_a, in_ready_a, found_a, inv_a, so_a} !== {4'b1010, 12'h4FF}) bad++;
    end
    compared++;
    if (bad !== 0) begin
      mismatched++;
      $display("FAIL hold_stable: got %0d unstable cycles want 0", bad);
    end
    out_ready_a = 1'b1;
    @(posedge clk);
    #1;
    out_ready_a = 1'b0;
    compared++;
    if ({out_valid_a, in_ready_a} !== 2'b01) begin
      mismatched++;
      $display("FAIL handover_idle: got vld/rdy=%b%b want 01", out_valid_a, in_ready_a);
    end
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    compared++;
    if (in_ready_a !== 1'b0) begin
      mismatched++;
      $display("FAIL handover_accept: got in_ready=%b want 0", in_ready_a);
    end
    wait_done(1'b0, lat);
    compared++;
    if (lat !== 1 || so_a !== 12'h0FF) begin
      mismatched++;
      $display("FAIL handover_result: got lat=%0d so=%h want 1/0ff", lat, so_a);
    end
    release_result(1'b0);
  endtask

  // in_valid pulsed mid-search and out_ready held during SEARCH have no effect.
  task automatic test_ignore_in_search();
    int lat;
    start_req(1'b0, 32'h00000104);
    out_ready_a = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    in_valid_a = 1'b1;
    in_value_a = 32'h000000FF;
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    @(posedge clk);
    #1;
    out_ready_a = 1'b0;
    lat = 0;
    for (int n = 5; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (out_valid_a === 1'b1) begin
        lat = n;
        break;
      end
    end
    compared++;
    if (lat !== 16 || so_a !== 12'hF41 || found_a !== 1'b1) begin
      mismatched++;
      $display("FAIL ignore_in_search: got lat=%0d so=%h found=%b want 16/f41/1", lat, so_a, found_a);
    end
    release_result(1'b0);
  endtask

  task automatic test_abort();
    int rose = 0;
    start_req(1'b0, 32'h00000104);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    compared++;
    if ({in_ready_a, out_valid_a} !== 2'b10) begin
      mismatched++;
      $display("FAIL abort_idle: got rdy/vld=%b%b want 10", in_ready_a, out_valid_a);
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid_a !== 1'b0) rose++;
    end
    compared++;
    if (rose !== 0) begin
      mismatched++;
      $display("FAIL abort_no_result: got out_valid high %0d cycles want 0", rose);
    end
  endtask

  task automatic test_random_roundtrip();
    logic [31:0] v, want;
    logic [7:0]  imm;
    int          rot, lat, kind;
    for (int i = 0; i < 1000; i++) begin
      kind = i % 3;
      imm  = 8'($urandom_range(0, 255));
      rot  = $urandom_range(0, 15);
      v    = ror32({24'd0, imm}, 2 * rot);
      if (kind == 1) v = ~v;
      if (kind == 2) v = $urandom;
      start_req(1'b0, v);
      wait_done(1'b0, lat);
      want = inv_a ? ~v : v;
      compared++;
      if (lat == 0 || (kind < 2 && found_a !== 1'b1) ||
          (found_a === 1'b1 && ror32({24'd0, so_a[7:0]}, 2 * int'(so_a[11:8])) !== want)) begin
        mismatched++;
        $display("FAIL random_roundtrip %h: got lat=%0d found=%b inv=%b so=%h want encodable round trip",
                 v, lat, found_a, inv_a, so_a);
      end
      release_result(1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_and_handover();
    test_ignore_in_search();
    test_abort();
    test_random_roundtrip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
